// File: rtl/mem_wb.sv
// MEM stage control and MEM/WB pipeline register: waits for load data, then extracts and extends it.
// Optional misaligned-load trap: define MEM_LOAD_MISALIGN_CHK_EN (adds the wb_load_misal output).
module mem_wb #(
  parameter int XLEN          = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_flush,
  input  logic                     ex_mem_valid,
  output logic                     mem_allowin,
  output logic                     mem_valid,
  input  logic                     wb_allowin,
  output logic                     mem_wb_valid,
  input  logic [XLEN-1:0]          mem_pc,
  input  logic [XLEN-1:0]          mem_inst,
  input  logic                     mem_req_rf,
  input  logic [RF_ADDR_WIDTH-1:0] mem_rf_waddr,
  input  logic [XLEN-1:0]          mem_alu_res,
  input  logic                     mem_is_load,
  input  logic [1:0]               mem_ls_addr_2low,
  input  logic [4:0]               mem_l_mask,
  input  logic                     mem_exp_flag,
  input  logic                     load_rsp_valid,
  input  logic [XLEN-1:0]          load_rsp_data,
  output logic                     wb_valid,
  output logic [XLEN-1:0]          wb_pc,
  output logic [XLEN-1:0]          wb_inst,
  output logic                     wb_req_rf,
  output logic [RF_ADDR_WIDTH-1:0] wb_rf_waddr,
  output logic [XLEN-1:0]          wb_rf_wdata,
`ifdef MEM_LOAD_MISALIGN_CHK_EN
  output logic                     wb_load_misal,
`endif
  output logic                     wb_exp_flag
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [XLEN-1:0]          inst;
    logic                     req_rf;
    logic [RF_ADDR_WIDTH-1:0] waddr;
    logic [XLEN-1:0]          wdata;
    logic                     exp;
    logic                     misal;
  } wb_pay_t;

  state_e          state_q, state_d;
  logic            mem_valid_q, mem_valid_d;
  logic            wb_valid_q, wb_valid_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] rsp_buf_q, rsp_buf_d;
  wb_pay_t         wb_q, wb_d;

  logic            misal, need_rsp, load_active, rsp_ok, mem_ready_go, rsp_cap;
  logic [XLEN-1:0] src, wdata;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

`ifdef MEM_LOAD_MISALIGN_CHK_EN
  assign misal = mem_is_load &&
                 (((mem_l_mask[1] || mem_l_mask[4]) && mem_ls_addr_2low[0]) ||
                  (mem_l_mask[2] && (mem_ls_addr_2low != 2'b00)));
`else
  assign misal = 1'b0;
`endif

  assign need_rsp     = mem_is_load && !mem_exp_flag && !misal;
  assign load_active  = mem_valid_q && need_rsp;
  // A response owed to a flushed load is swallowed so it cannot complete a younger load.
  assign rsp_ok       = load_rsp_valid && !drop_q;
  assign mem_ready_go = !need_rsp || (state_q == S_HOLD) || rsp_ok;
  assign mem_wb_valid = mem_valid_q && mem_ready_go;
  assign mem_allowin  = !mem_valid_q || (mem_ready_go && wb_allowin);
  assign mem_valid    = mem_valid_q;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_WAIT: begin
        if (!load_active)  state_d = S_IDLE;
        else if (!rsp_ok)  state_d = S_WAIT;
        else               state_d = wb_allowin ? S_IDLE : S_HOLD;
      end
      S_HOLD:  if (wb_allowin) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (pipe_flush) state_d = S_IDLE;
  end

  // FSM: outputs
  always_comb begin
    rsp_cap   = (state_q != S_HOLD) && load_active && rsp_ok && !wb_allowin && !pipe_flush;
    rsp_buf_d = rsp_cap ? load_rsp_data : rsp_buf_q;
    drop_d    = (drop_q || (pipe_flush && load_active && state_q != S_HOLD)) && !load_rsp_valid;
    src       = (state_q == S_HOLD) ? rsp_buf_q : load_rsp_data;
  end

  always_comb begin
    byte_v = src[{mem_ls_addr_2low, 3'b000} +: 8];
    half_v = src[{mem_ls_addr_2low[1], 4'b0000} +: 16];
    if (!mem_is_load)       wdata = mem_alu_res;
    else if (mem_l_mask[0]) wdata = {{(XLEN-8){byte_v[7]}}, byte_v};
    else if (mem_l_mask[1]) wdata = {{(XLEN-16){half_v[15]}}, half_v};
    else if (mem_l_mask[3]) wdata = {{(XLEN-8){1'b0}}, byte_v};
    else if (mem_l_mask[4]) wdata = {{(XLEN-16){1'b0}}, half_v};
    else                    wdata = src;
  end

  always_comb begin
    mem_valid_d = mem_valid_q;
    wb_valid_d  = wb_valid_q;
    wb_d        = wb_q;
    if (pipe_flush) begin
      mem_valid_d = 1'b0;
      wb_valid_d  = 1'b0;
      wb_d        = '0;
    end else begin
      if (mem_allowin) mem_valid_d = ex_mem_valid;
      if (wb_allowin)  wb_valid_d  = mem_wb_valid;
      if (mem_wb_valid && wb_allowin) begin
        wb_d.pc     = mem_pc;
        wb_d.inst   = mem_inst;
        wb_d.req_rf = mem_req_rf && !mem_exp_flag && !misal;
        wb_d.waddr  = mem_rf_waddr;
        wb_d.wdata  = wdata;
        wb_d.exp    = mem_exp_flag || misal;
        wb_d.misal  = misal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      drop_q      <= 1'b0;
      rsp_buf_q   <= '0;
      wb_q        <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
      drop_q      <= drop_d;
      rsp_buf_q   <= rsp_buf_d;
      wb_q        <= wb_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_pc       = wb_q.pc;
  assign wb_inst     = wb_q.inst;
  assign wb_req_rf   = wb_q.req_rf && wb_valid_q;
  assign wb_rf_waddr = wb_q.waddr;
  assign wb_rf_wdata = wb_q.wdata;
  assign wb_exp_flag = wb_q.exp;
`ifdef MEM_LOAD_MISALIGN_CHK_EN
  assign wb_load_misal = wb_q.misal;
`else
  logic unused_misal;
  assign unused_misal = wb_q.misal;
`endif

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: ALU pass, load extraction, response wait, HOLD backpressure, flush.
module tb_mem_wb;
  logic        clk = 1'b0;
  logic        rst_n, pipe_flush, ex_mem_valid, wb_allowin;
  logic        mem_allowin, mem_valid, mem_wb_valid;
  logic [31:0] mem_pc, mem_inst, mem_alu_res, load_rsp_data;
  logic        mem_req_rf, mem_is_load, mem_exp_flag, load_rsp_valid;
  logic [4:0]  mem_rf_waddr, mem_l_mask;
  logic [1:0]  mem_ls_addr_2low;
  logic        wb_valid, wb_req_rf, wb_exp_flag;
  logic [31:0] wb_pc, wb_inst, wb_rf_wdata;
  logic [4:0]  wb_rf_waddr;
`ifdef MEM_LOAD_MISALIGN_CHK_EN
  logic        wb_load_misal;
`endif
  int tests = 0, fails = 0;

  localparam logic [4:0] LB = 5'b00001, LH = 5'b00010, LW = 5'b00100, LBU = 5'b01000, LHU = 5'b10000;

  mem_wb dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush), .ex_mem_valid(ex_mem_valid),
    .mem_allowin(mem_allowin), .mem_valid(mem_valid), .wb_allowin(wb_allowin),
    .mem_wb_valid(mem_wb_valid), .mem_pc(mem_pc), .mem_inst(mem_inst),
    .mem_req_rf(mem_req_rf), .mem_rf_waddr(mem_rf_waddr), .mem_alu_res(mem_alu_res),
    .mem_is_load(mem_is_load), .mem_ls_addr_2low(mem_ls_addr_2low), .mem_l_mask(mem_l_mask),
    .mem_exp_flag(mem_exp_flag), .load_rsp_valid(load_rsp_valid), .load_rsp_data(load_rsp_data),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_req_rf(wb_req_rf),
    .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
`ifdef MEM_LOAD_MISALIGN_CHK_EN
    .wb_load_misal(wb_load_misal),
`endif
    .wb_exp_flag(wb_exp_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic set_idle();
    pipe_flush = 0; ex_mem_valid = 0; wb_allowin = 1; load_rsp_valid = 0; load_rsp_data = 0;
    mem_pc = 0; mem_inst = 0; mem_alu_res = 0; mem_req_rf = 0; mem_rf_waddr = 0;
    mem_is_load = 0; mem_ls_addr_2low = 0; mem_l_mask = 0; mem_exp_flag = 0;
  endtask

  task automatic settle(); set_idle(); tick(); tick(); endtask

  // Push one instruction into MEM; returns with its payload presented and settled.
  task automatic issue(input logic ld, input logic [4:0] mask, input logic [1:0] a,
                       input logic [31:0] alu, input logic exp);
    ex_mem_valid = 1; tick(); ex_mem_valid = 0;
    mem_is_load = ld; mem_l_mask = mask; mem_ls_addr_2low = a; mem_alu_res = alu;
    mem_exp_flag = exp; mem_req_rf = 1; mem_rf_waddr = 5'd7;
    mem_pc = 32'h0000_1000; mem_inst = 32'h0000_0013; #1;
  endtask

  task automatic test_reset();
    set_idle(); rst_n = 0; #12;
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_valid act=%0h exp=0", mem_valid); end
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wb_valid act=%0h exp=0", wb_valid); end
    tests++; if (mem_allowin !== 1'b1) begin fails++; $display("FAIL reset_allowin act=%0h exp=1", mem_allowin); end
    tests++; if (wb_rf_wdata !== 32'h0 || wb_req_rf !== 1'b0 || wb_exp_flag !== 1'b0)
      begin fails++; $display("FAIL reset_wb_payload wdata=%h req=%0h exp=%0h want 0", wb_rf_wdata, wb_req_rf, wb_exp_flag); end
    rst_n = 1; tick();
  endtask

  task automatic test_alu();
    settle();
    issue(0, 5'b0, 2'd0, 32'h0000_1234, 0);
    tests++; if (mem_wb_valid !== 1'b1) begin fails++; $display("FAIL alu_ready act=%0h exp=1", mem_wb_valid); end
    tick();
    tests++; if (wb_valid !== 1'b1 || wb_rf_wdata !== 32'h1234 || wb_req_rf !== 1'b1)
      begin fails++; $display("FAIL alu_wb valid=%0h wdata=%h req=%0h want 1/00001234/1", wb_valid, wb_rf_wdata, wb_req_rf); end
    tests++; if (wb_rf_waddr !== 5'd7 || wb_pc !== 32'h1000 || wb_inst !== 32'h13)
      begin fails++; $display("FAIL alu_payload waddr=%0d pc=%h inst=%h want 7/1000/13", wb_rf_waddr, wb_pc, wb_inst); end
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL alu_mem_drain act=%0h exp=0", mem_valid); end
  endtask

  task automatic test_load_extract();
    logic [4:0]  tm[7];
    logic [1:0]  ta[7];
    logic [31:0] td[7], te[7];
    tm[0] = LB;  ta[0] = 2'd3; td[0] = 32'h80FF_0000; te[0] = 32'hFFFF_FF80;
    tm[1] = LBU; ta[1] = 2'd3; td[1] = 32'h80FF_0000; te[1] = 32'h0000_0080;
    tm[2] = LH;  ta[2] = 2'd2; td[2] = 32'h8001_0000; te[2] = 32'hFFFF_8001;
    tm[3] = LHU; ta[3] = 2'd2; td[3] = 32'h8001_0000; te[3] = 32'h0000_8001;
    tm[4] = LW;  ta[4] = 2'd0; td[4] = 32'hDEAD_BEEF; te[4] = 32'hDEAD_BEEF;
    tm[5] = LB;  ta[5] = 2'd1; td[5] = 32'h0000_7F00; te[5] = 32'h0000_007F;
    tm[6] = LH;  ta[6] = 2'd0; td[6] = 32'h1234_F00D; te[6] = 32'hFFFF_F00D;
    for (int i = 0; i < 7; i++) begin
      settle();
      issue(1, tm[i], ta[i], 32'hAAAA_AAAA, 0);
      load_rsp_valid = 1; load_rsp_data = td[i]; #1;
      tick(); load_rsp_valid = 0; load_rsp_data = 0; #1;
      tests++; if (wb_valid !== 1'b1 || wb_rf_wdata !== te[i] || wb_req_rf !== 1'b1)
        begin fails++; $display("FAIL load_extract[%0d] valid=%0h wdata=%h req=%0h want 1/%h/1", i, wb_valid, wb_rf_wdata, wb_req_rf, te[i]); end
    end
  endtask

  task automatic test_load_latency();
    settle();
    issue(1, LW, 2'd0, 32'h0, 0);
    for (int c = 0; c < 3; c++) begin
      tests++; if (mem_allowin !== 1'b0 || wb_valid !== 1'b0 || mem_wb_valid !== 1'b0)
        begin fails++; $display("FAIL lat_wait[%0d] allowin=%0h wb_valid=%0h ready=%0h want 0/0/0", c, mem_allowin, wb_valid, mem_wb_valid); end
      tick();
    end
    load_rsp_valid = 1; load_rsp_data = 32'h0BAD_F00D; #1;
    tests++; if (wb_valid !== 1'b0 || mem_allowin !== 1'b1)
      begin fails++; $display("FAIL lat_rsp_cycle wb_valid=%0h allowin=%0h want 0/1", wb_valid, mem_allowin); end
    tick(); load_rsp_valid = 0;
    tests++; if (wb_valid !== 1'b1 || wb_rf_wdata !== 32'h0BAD_F00D)
      begin fails++; $display("FAIL lat_wb valid=%0h wdata=%h want 1/0badf00d", wb_valid, wb_rf_wdata); end
  endtask

  task automatic test_hold();
    settle();
    issue(1, LW, 2'd0, 32'h0, 0);
    wb_allowin = 0; load_rsp_valid = 1; load_rsp_data = 32'hCAFE_F00D; #1;
    tests++; if (mem_wb_valid !== 1'b1 || mem_allowin !== 1'b0)
      begin fails++; $display("FAIL hold_rsp ready=%0h allowin=%0h want 1/0", mem_wb_valid, mem_allowin); end
    tick(); load_rsp_valid = 0; load_rsp_data = 32'h5555_5555;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++; if (mem_valid !== 1'b1 || wb_valid !== 1'b0 || mem_wb_valid !== 1'b1)
        begin fails++; $display("FAIL hold_stall[%0d] mem_valid=%0h wb_valid=%0h ready=%0h want 1/0/1", c, mem_valid, wb_valid, mem_wb_valid); end
      if (c == 0) tick();
    end
    wb_allowin = 1; #1;
    tests++; if (mem_allowin !== 1'b1) begin fails++; $display("FAIL hold_release allowin=%0h exp=1", mem_allowin); end
    tick();
    tests++; if (wb_valid !== 1'b1 || wb_rf_wdata !== 32'hCAFE_F00D)
      begin fails++; $display("FAIL hold_wb valid=%0h wdata=%h want 1/cafef00d", wb_valid, wb_rf_wdata); end
    tick();
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL hold_no_dup wb_valid=%0h exp=0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    settle();
    ex_mem_valid = 1; tick();
    mem_alu_res = 32'h11; mem_req_rf = 1; #1;
    tick();
    tests++; if (wb_valid !== 1'b1 || wb_rf_wdata !== 32'h11 || mem_valid !== 1'b1)
      begin fails++; $display("FAIL b2b_first wb_valid=%0h wdata=%h mem_valid=%0h want 1/11/1", wb_valid, wb_rf_wdata, mem_valid); end
    ex_mem_valid = 0; mem_alu_res = 32'h22; #1;
    tick();
    tests++; if (wb_valid !== 1'b1 || wb_rf_wdata !== 32'h22)
      begin fails++; $display("FAIL b2b_second wb_valid=%0h wdata=%h want 1/22", wb_valid, wb_rf_wdata); end
    tick();
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain wb_valid=%0h exp=0", wb_valid); end
  endtask

  task automatic test_flush();
    settle();
    issue(1, LW, 2'd0, 32'h0, 0);
    tick();
    pipe_flush = 1; tick(); pipe_flush = 0; #1;
    tests++; if (mem_valid !== 1'b0 || wb_valid !== 1'b0 || mem_allowin !== 1'b1 || wb_req_rf !== 1'b0)
      begin fails++; $display("FAIL flush_clear mem_valid=%0h wb_valid=%0h allowin=%0h req=%0h want 0/0/1/0", mem_valid, wb_valid, mem_allowin, wb_req_rf); end
    // Younger load in MEM when the stale response arrives: it must not be consumed.
    issue(1, LW, 2'd0, 32'h0, 0);
    load_rsp_valid = 1; load_rsp_data = 32'h0000_0055; #1;
    tests++; if (mem_wb_valid !== 1'b0) begin fails++; $display("FAIL flush_stale_ready ready=%0h exp=0", mem_wb_valid); end
    tick(); load_rsp_valid = 0; #1;
    tests++; if (wb_valid !== 1'b0 || wb_req_rf !== 1'b0)
      begin fails++; $display("FAIL flush_stale_wb wb_valid=%0h req=%0h want 0/0", wb_valid, wb_req_rf); end
    load_rsp_valid = 1; load_rsp_data = 32'h1234_5678; tick(); load_rsp_valid = 0;
    tests++; if (wb_valid !== 1'b1 || wb_rf_wdata !== 32'h1234_5678)
      begin fails++; $display("FAIL flush_recover wb_valid=%0h wdata=%h want 1/12345678", wb_valid, wb_rf_wdata); end
    settle();
    issue(0, 5'b0, 2'd0, 32'h0000_ABCD, 0);
    tick(); wb_allowin = 0; pipe_flush = 1; tick(); pipe_flush = 0;
    tests++; if (wb_valid !== 1'b0 || wb_rf_wdata !== 32'h0 || wb_pc !== 32'h0)
      begin fails++; $display("FAIL flush_wb wb_valid=%0h wdata=%h pc=%h want 0/0/0", wb_valid, wb_rf_wdata, wb_pc); end
  endtask

  task automatic test_exception();
    settle();
    issue(1, LW, 2'd0, 32'h0, 1);
    tests++; if (mem_wb_valid !== 1'b1) begin fails++; $display("FAIL exc_ready act=%0h exp=1", mem_wb_valid); end
    tick();
    tests++; if (wb_valid !== 1'b1 || wb_req_rf !== 1'b0 || wb_exp_flag !== 1'b1)
      begin fails++; $display("FAIL exc_wb valid=%0h req=%0h exp=%0h want 1/0/1", wb_valid, wb_req_rf, wb_exp_flag); end
`ifdef MEM_LOAD_MISALIGN_CHK_EN
    settle();
    issue(1, LW, 2'd1, 32'h0, 0);
    tests++; if (mem_wb_valid !== 1'b1) begin fails++; $display("FAIL misal_ready act=%0h exp=1", mem_wb_valid); end
    tick();
    tests++; if (wb_exp_flag !== 1'b1 || wb_load_misal !== 1'b1 || wb_req_rf !== 1'b0)
      begin fails++; $display("FAIL misal_wb exp=%0h misal=%0h req=%0h want 1/1/0", wb_exp_flag, wb_load_misal, wb_req_rf); end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_extract();
    test_load_latency();
    test_hold();
    test_back_to_back();
    test_flush();
    test_exception();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_wb.md
Name: mem_wb

Overview:
- MEM stage control plus the MEM/WB pipeline register of the in-order RISC-V core.
- Consumes the MEM-stage payload registered by the EX/MEM register.
- Waits for the data-memory load response and extracts and extends load data by mask and byte offset.
- Presents the write-back payload to WB under the same valid/allowin handshake used throughout the pipeline.

Parameters:
- XLEN, 32, datapath width.
- RF_ADDR_WIDTH, 5, register-file address width.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- pipe_flush  input  1  pipeline flush (trap/redirect)
- ex_mem_valid  input  1  EX stage holds a valid instruction ready to advance
- mem_allowin  output  1  MEM can accept a new instruction this cycle
- mem_valid  output  1  MEM holds a valid instruction
- wb_allowin  input  1  WB accepts this cycle
- mem_wb_valid  output  1  mem_valid && mem_ready_go
- mem_pc, mem_inst  input  XLEN  MEM-stage pc and instruction
- mem_req_rf  input  1  instruction writes the register file
- mem_rf_waddr  input  RF_ADDR_WIDTH  destination register
- mem_alu_res  input  XLEN  ALU result / effective address
- mem_is_load  input  1  load instruction
- mem_ls_addr_2low  input  2  address bits [1:0]
- mem_l_mask  input  5  one-hot load type: [0]LB [1]LH [2]LW [3]LBU [4]LHU
- mem_exp_flag  input  1  exception already flagged upstream
- load_rsp_valid  input  1  one-cycle load data response
- load_rsp_data  input  XLEN  raw aligned word
- wb_valid  output  1  WB holds a valid instruction
- wb_pc, wb_inst  output  XLEN  WB pc and instruction
- wb_req_rf  output  1  RF write request; gated by wb_valid
- wb_rf_waddr  output  RF_ADDR_WIDTH  RF write address
- wb_rf_wdata  output  XLEN  RF write data
- wb_exp_flag  output  1  exception flag to the trap unit

Behaviour:
- All registers reset asynchronously on rst_n low. Reset values: every output register 0; FSM in IDLE.
- mem_valid update, priority order:
  - flush: cleared to 0.
  - else if mem_allowin: mem_valid <= ex_mem_valid.
  - else: holds.
- mem_allowin = !mem_valid || (mem_ready_go && wb_allowin).
- mem_ready_go:
  - Non-load or mem_exp_flag: 1.
  - Load: 1 when load_rsp_valid is high this cycle or a response is already captured.
- Load FSM (3 states):
  - IDLE -> WAIT when a valid load enters MEM.
  - WAIT, load_rsp_valid && wb_allowin: -> IDLE, or -> WAIT if another valid load enters the same cycle.
  - WAIT, load_rsp_valid && !wb_allowin: capture data in rsp_buf -> HOLD.
  - HOLD -> IDLE/WAIT when wb_allowin.
- Extraction (combinational from rsp_buf or load_rsp_data):
  - Byte select = data >> (8*addr_2low). Half select = data >> (16*addr_2low[1]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Non-load: wdata = mem_alu_res.
- Register transfer: when mem_wb_valid && wb_allowin, the WB register captures pc, inst, req_rf, waddr, wdata and exp_flag. Otherwise holds.
- wb_valid update, priority order:
  - flush: 0.
  - else if wb_allowin: wb_valid <= mem_wb_valid.
  - else: holds.
- Exceptions: mem_exp_flag forces wb_req_rf = 0 for that instruction.
- Flush:
  - Clears mem_valid, wb_valid, all WB payload registers and the FSM to IDLE in the same edge.
  - A load response arriving in the flush cycle or later for the flushed load is discarded.
  - load_rsp_valid in IDLE is ignored.
- Flush has priority over every simultaneous event.
- Latency: non-load 1 cycle MEM->WB. Load 1 cycle after load_rsp_valid.

Optional Feature:
- Macro MEM_LOAD_MISALIGN_CHK_EN.
- When defined:
  - A load is misaligned if LH/LHU has addr_2low[0]=1, or LW has addr_2low!=0.
  - Misaligned loads are ready immediately with no response wait.
  - wb_exp_flag=1, wb_req_rf=0.
  - Extra output wb_load_misal (1 bit, reset 0) = 1 for that instruction.
- When undefined: no check; data is extracted from whatever bytes are selected, and the port is absent.

Test Plan:
- ALU op, mem_alu_res=0x1234, req_rf=1, wb_allowin=1 -> next cycle wb_valid=1, wb_rf_wdata=0x1234, wb_req_rf=1.
- LB, addr_2low=3, rsp data 0x80FF_0000 -> wb_rf_wdata=0xFFFF_FF80. LBU same -> 0x0000_0080.
- LH, addr_2low=2, rsp 0x8001_0000 -> 0xFFFF_8001. LHU -> 0x0000_8001.
- LW issued, rsp arrives 3 cycles later -> mem_allowin=0 while waiting; wb_valid rises exactly one cycle after load_rsp_valid.
- Response arrives with wb_allowin=0 for 2 cycles -> data held in HOLD, correct value delivered once wb_allowin=1, no duplicate wb_valid.
- Flush while in WAIT, then late load_rsp_valid -> mem_valid=0, wb_valid=0, FSM IDLE, no RF write. With MEM_LOAD_MISALIGN_CHK_EN: LW at addr_2low=1 -> wb_exp_flag=1, wb_load_misal=1, wb_req_rf=0.
